// File: rtl/serial_cmp_pkg.sv
// -----------------------------------------------------------------------------
// serial_cmp_pkg
// Shared definitions for the bit-serial magnitude comparator.
//   - cmp_state_t    : FSM state encoding (IDLE=00, CMP=01, DONE=10)
//   - CMP_WIDTH_DEF  : default operand width
//   - cnt_width()    : bit-counter width for a given operand width
// -----------------------------------------------------------------------------
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CMP  = 2'b01,
        ST_DONE = 2'b10
    } cmp_state_t;

    localparam int unsigned CMP_WIDTH_DEF = 4;

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int unsigned CMP_CNT_W_DEF = cnt_width(CMP_WIDTH_DEF);

endpackage

// File: rtl/serial_cmp_cell.sv
// -----------------------------------------------------------------------------
// serial_cmp_cell
// Combinational 1-bit compare stage.
//   ai, bi : operand bits
//   gt     : ai > bi
//   eq     : ai == bi
//   lt     : ai < bi
// -----------------------------------------------------------------------------
module serial_cmp_cell (
    input  logic ai,
    input  logic bi,
    output logic gt,
    output logic eq,
    output logic lt
);

    assign gt = ai & ~bi;
    assign eq = ~(ai ^ bi);
    assign lt = ~ai & bi;

endmodule

// File: rtl/serial_comparator_4bit_fsm.sv
// -----------------------------------------------------------------------------
// serial_comparator_4bit_fsm
// Bit-serial magnitude comparator: operands are consumed MSB-first, one bit
// per clock, under a start/done handshake. Result x/y/z (A>B, A==B, A<B) is
// registered and held until the next accepted compare.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : compare request, sampled only in IDLE
//   a, b         : operands, captured on the accepting edge
//   busy         : high while in CMP
//   done         : one-cycle pulse; x/y/z valid from this cycle on
//   x, y, z      : A > B, A == B, A < B
//   state_dbg    : current FSM state (cmp_state_t encoding)
//
// Handshake: start is a level request; it is accepted on any rising edge where
// the FSM is in IDLE. Requests while busy or in DONE are dropped, not queued.
// done rises k+1 edges after the accepting edge (k = bits examined).
//
// Build option SERIAL_CMP_EARLY_EXIT_EN:
//   defined   : CMP stops at the first differing bit.
//   undefined : CMP always examines WIDTH bits (constant time); the first
//               difference is held in a sticky decided flag.
// -----------------------------------------------------------------------------
import serial_cmp_pkg::*;

module serial_comparator_4bit_fsm #(
    parameter int unsigned WIDTH = CMP_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             x,
    output logic             y,
    output logic             z,
    output logic [1:0]       state_dbg
);

    localparam int unsigned     CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    cmp_state_t       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             x_q;
    logic             y_q;
    logic             z_q;

`ifndef SERIAL_CMP_EARLY_EXIT_EN
    // Sticky first-difference record for the constant-time build.
    logic             dec_q;
    logic             gt_q;
    logic             lt_q;
`endif

    logic bit_gt;
    logic bit_eq;
    logic bit_lt;

    serial_cmp_cell u_cell (
        .ai (a_q[WIDTH-1]),
        .bi (b_q[WIDTH-1]),
        .gt (bit_gt),
        .eq (bit_eq),
        .lt (bit_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            z_q     <= 1'b0;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
            dec_q   <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CMP;
`ifndef SERIAL_CMP_EARLY_EXIT_EN
                        dec_q   <= 1'b0;
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
`endif
                    end
                end

                ST_CMP: begin
                    a_q <= a_q << 1;
                    b_q <= b_q << 1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                    // At the last bit with no difference, bit_eq=1 yields y=1.
                    if (!bit_eq || (cnt_q == LAST_CNT)) begin
                        x_q     <= bit_gt;
                        y_q     <= bit_eq;
                        z_q     <= bit_lt;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`else
                    if (!dec_q && !bit_eq) begin
                        dec_q <= 1'b1;
                        gt_q  <= bit_gt;
                        lt_q  <= bit_lt;
                    end
                    if (cnt_q == LAST_CNT) begin
                        // Undecided at the LSB means the LSB itself decides.
                        if (dec_q) begin
                            x_q <= gt_q;
                            y_q <= 1'b0;
                            z_q <= lt_q;
                        end else begin
                            x_q <= bit_gt;
                            y_q <= bit_eq;
                            z_q <= bit_lt;
                        end
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end

                ST_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign x         = x_q;
    assign y         = y_q;
    assign z         = z_q;
    assign state_dbg = state_q;

endmodule
